counter_updown_mod: RTL and testbench
=====================================

Name: counter_updown_mod

Overview:
- Parametrised synchronous up/down counter with programmable modulus, parallel load, synchronous clear, count enable with built-in prescaler, and wrap or saturate mode.
- Next generation of the team's fixed-width up counters.
- Used as the general-purpose timer/event counter in datapath and control blocks.
- Provides a registered terminal-count pulse so counters can be cascaded.

Parameters:
- WIDTH, 8, counter width in bits (≥2).
- MOD_MAX, 2**WIDTH-1, largest count value; range is 0..MOD_MAX; must satisfy 1 ≤ MOD_MAX ≤ 2**WIDTH-1.
- SATURATE, 0, boundary mode: 0 = wrap, 1 = hold at boundary.
- PRESCALE, 1, number of enabled clocks per count step (≥1).

Ports:
- clk, in, 1, rising-edge clock.
- reset_al_in, in, 1, asynchronous active-low reset.
- clear_in, in, 1, synchronous clear.
- load_in, in, 1, synchronous parallel load.
- d_in, in, WIDTH, load value.
- en_in, in, 1, count enable.
- up_in, in, 1, direction: 1 = up, 0 = down.
- count_out, out, WIDTH, registered count.
- tc_out, out, 1, registered terminal-count pulse.
- at_max_out, out, 1, combinational: count_out == MOD_MAX.
- at_min_out, out, 1, combinational: count_out == 0.

Behaviour:
- Reset (reset_al_in = 0): immediate, asynchronous. count_out = 0, tc_out = 0, prescaler = 0. Holds while low.
- Release: first count action on the first rising clk edge after reset_al_in goes high.
- Per-edge priority: clear_in > load_in > tick > hold.
- clear_in: count_out ← 0; prescaler ← 0; tc_out ← 0.
- load_in: count_out ← d_in, clamped to MOD_MAX if d_in > MOD_MAX; prescaler ← 0; tc_out ← 0.
- tick:
  - PRESCALE = 1: tick = en_in.
  - PRESCALE > 1: prescaler counts 0..PRESCALE-1 on each en_in cycle; tick = en_in && prescaler == PRESCALE-1; prescaler wraps to 0 on tick.
  - en_in = 0: prescaler holds.
- Up tick:
  - count < MOD_MAX: count + 1.
  - count == MOD_MAX: wraps to 0 (SATURATE = 0) or holds (SATURATE = 1).
- Down tick:
  - count > 0: count - 1.
  - count == 0: wraps to MOD_MAX (SATURATE = 0) or holds (SATURATE = 1).
- tc_out:
  - 1 for exactly the cycle after a tick taken at the boundary in the counting direction (MOD_MAX when up, 0 when down), in both modes; 0 otherwise.
  - Latency: one clock from the boundary tick.
  - In SATURATE mode, tc_out pulses on every tick while held at the boundary.
- up_in is sampled only on tick; a direction change mid-prescale takes effect at the next tick.
- Arithmetic: WIDTH-bit, no overflow. Wrap is to the explicit modulus value, never the natural 2**WIDTH rollover unless MOD_MAX = 2**WIDTH-1.
- Mid-operation reset: immediate return to reset values; the prescaler phase is lost.
- Simultaneous clear_in and load_in: clear wins.
- Simultaneous load_in and tick: load wins; no count step, no tc_out.

Decomposition:
- Shared counters package holds:
  - direction constants (DIR_UP = 1, DIR_DOWN = 0);
  - mode constants (MODE_WRAP = 0, MODE_SAT = 1);
  - a clog2 helper function for prescaler width.
- One sub-module: counter_prescaler, parameter PRESCALE.
  - Inputs: clk, reset_al_in, clr_in (clear or load), en_in.
  - Output: tick_out.
  - At PRESCALE = 1 it degenerates to tick_out = en_in.

Test Plan:
1. Reset: WIDTH = 4, MOD_MAX = 9; assert reset_al_in low mid-clock with count = 5 → count_out = 0 and tc_out = 0 immediately, with no clk edge needed.
2. Wrap up: MOD_MAX = 9, SATURATE = 0, en_in = 1, up_in = 1 from 0 → sequence 0..9, then 0; tc_out = 1 only in the cycle count_out first shows 0.
3. Wrap down and saturate:
   - SATURATE = 0, up_in = 0 from 2 → 2, 1, 0, 9 with tc_out pulse.
   - SATURATE = 1 → 2, 1, 0, 0, 0 with tc_out high on each tick at 0.
4. Load and clamp: MOD_MAX = 9, load d_in = 12 → count_out = 9, at_max_out = 1. Load together with en_in = 1 → count_out = d_in, no increment.
5. Priority: clear_in = load_in = en_in = 1 with count 7 → count_out = 0, tc_out = 0.
6. Prescale: PRESCALE = 3, en_in = 1 continuously → count steps every 3rd clock. Drop en_in for 2 cycles mid-phase → phase holds. load_in restarts the phase, so the next step occurs 3 enabled clocks after the load.

Source files
------------

// File: rtl/counter_updown_mod_pkg.sv
// Shared definitions for the up/down counter family.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: none.
package counter_updown_mod_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam bit MODE_WRAP = 1'b0;
   localparam bit MODE_SAT  = 1'b1;

   // Bits needed to hold 0..value-1, never less than one.
   function automatic int clog2_min1(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >>> 1;
      end
      return (result < 1) ? 1 : result;
   endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Divides the count enable: one tick per PRESCALE enabled clocks.
// Latency: tick_out is combinational from en_in and the registered phase.
// Backpressure: none; phase holds while en_in is low, restarts on clr_in.
module counter_prescaler
   import counter_updown_mod_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset_al_in,
   input  logic clr_in,
   input  logic en_in,
   output logic tick_out
);

   if (PRESCALE <= 1) begin : g_bypass
      logic unused_prescaler_inputs;
      assign unused_prescaler_inputs = &{1'b0, clk, reset_al_in, clr_in};
      assign tick_out = en_in;
   end else begin : g_divide
      localparam int               PW   = clog2_min1(PRESCALE);
      localparam logic [PW-1:0]    LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] phase;

      always_ff @(posedge clk or negedge reset_al_in) begin
         if (!reset_al_in) begin
            phase <= '0;
         end else if (clr_in) begin
            phase <= '0;
         end else if (en_in) begin
            phase <= (phase == LAST) ? '0 : phase + PW'(1);
         end
      end

      assign tick_out = en_in && (phase == LAST);
   end

endmodule

// File: rtl/counter_updown_mod.sv
// Up/down counter with modulus, load, clear, prescaled enable, wrap/saturate.
// Latency: count_out and tc_out registered, one clock; at_max/at_min combinational.
// Backpressure: none; clear > load > tick > hold on every edge.
module counter_updown_mod
   import counter_updown_mod_pkg::*;
#(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] MOD_MAX  = {WIDTH{1'b1}},
   parameter bit               SATURATE = MODE_WRAP,
   parameter int               PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset_al_in,
   input  logic             clear_in,
   input  logic             load_in,
   input  logic [WIDTH-1:0] d_in,
   input  logic             en_in,
   input  logic             up_in,
   output logic [WIDTH-1:0] count_out,
   output logic             tc_out,
   output logic             at_max_out,
   output logic             at_min_out
);

   logic             tick;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count_nxt;
   logic             tc_nxt;

   counter_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk         (clk),
      .reset_al_in (reset_al_in),
      .clr_in      (clear_in | load_in),
      .en_in       (en_in),
      .tick_out    (tick)
   );

   assign at_max_out = (count_out == MOD_MAX);
   assign at_min_out = (count_out == '0);
   assign load_val   = (d_in > MOD_MAX) ? MOD_MAX : d_in;

   // A boundary tick always pulses tc, whether the count wraps or holds.
   always_comb begin
      count_nxt = count_out;
      tc_nxt    = 1'b0;
      if (clear_in) begin
         count_nxt = '0;
      end else if (load_in) begin
         count_nxt = load_val;
      end else if (tick) begin
         if (up_in == DIR_UP) begin
            if (!at_max_out) begin
               count_nxt = count_out + WIDTH'(1);
            end else begin
               tc_nxt = 1'b1;
               if (SATURATE == MODE_WRAP) count_nxt = '0;
            end
         end else begin
            if (!at_min_out) begin
               count_nxt = count_out - WIDTH'(1);
            end else begin
               tc_nxt = 1'b1;
               if (SATURATE == MODE_WRAP) count_nxt = MOD_MAX;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_al_in) begin
      if (!reset_al_in) begin
         count_out <= '0;
         tc_out    <= 1'b0;
      end else begin
         count_out <= count_nxt;
         tc_out    <= tc_nxt;
      end
   end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed table plus hand sequences for counter_updown_mod (wrap, saturate, prescale).
module tb_counter_updown_mod;

   logic       clk = 1'b0;
   logic       reset_al_in;
   logic       clear_in;
   logic       load_in;
   logic [3:0] d_in;
   logic       en_in;
   logic       up_in;

   logic [3:0] cnt_w, cnt_s, cnt_p;
   logic       tc_w, tc_s, tc_p;
   logic       mx_w, mx_s, mx_p;
   logic       mn_w, mn_s, mn_p;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   counter_updown_mod #(.WIDTH(4), .MOD_MAX(4'd9), .SATURATE(1'b0), .PRESCALE(1)) dut_wrap (
      .clk(clk), .reset_al_in(reset_al_in), .clear_in(clear_in), .load_in(load_in),
      .d_in(d_in), .en_in(en_in), .up_in(up_in),
      .count_out(cnt_w), .tc_out(tc_w), .at_max_out(mx_w), .at_min_out(mn_w));

   counter_updown_mod #(.WIDTH(4), .MOD_MAX(4'd9), .SATURATE(1'b1), .PRESCALE(1)) dut_sat (
      .clk(clk), .reset_al_in(reset_al_in), .clear_in(clear_in), .load_in(load_in),
      .d_in(d_in), .en_in(en_in), .up_in(up_in),
      .count_out(cnt_s), .tc_out(tc_s), .at_max_out(mx_s), .at_min_out(mn_s));

   counter_updown_mod #(.WIDTH(4), .MOD_MAX(4'd9), .SATURATE(1'b0), .PRESCALE(3)) dut_pre (
      .clk(clk), .reset_al_in(reset_al_in), .clear_in(clear_in), .load_in(load_in),
      .d_in(d_in), .en_in(en_in), .up_in(up_in),
      .count_out(cnt_p), .tc_out(tc_p), .at_max_out(mx_p), .at_min_out(mn_p));

   typedef struct {
      string      name;
      int         sel;   // 0 = wrap, 1 = saturate, 2 = prescale-3
      logic       clr;
      logic       ld;
      logic [3:0] d;
      logic       en;
      logic       up;
      logic [3:0] cnt;
      logic       tc;
      logic       mx;
      logic       mn;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string n, input int s, input logic c, input logic l,
                               input logic [3:0] d, input logic e, input logic u,
                               input logic [3:0] ec, input logic et, input logic emx,
                               input logic emn);
      vec_t v;
      v.name = n; v.sel = s; v.clr = c; v.ld = l; v.d = d; v.en = e; v.up = u;
      v.cnt = ec; v.tc = et; v.mx = emx; v.mn = emn;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input int sel, input string name, input logic [3:0] ec,
                        input logic et, input logic emx, input logic emn);
      logic [3:0] ac;
      logic       at, amx, amn;
      case (sel)
         0:       begin ac = cnt_w; at = tc_w; amx = mx_w; amn = mn_w; end
         1:       begin ac = cnt_s; at = tc_s; amx = mx_s; amn = mn_s; end
         default: begin ac = cnt_p; at = tc_p; amx = mx_p; amn = mn_p; end
      endcase
      vectors++;
      if ({ac, at, amx, amn} !== {ec, et, emx, emn}) begin
         miscompares++;
         $display("FAIL %s: got count=%0d tc=%b max=%b min=%b, want count=%0d tc=%b max=%b min=%b",
                  name, ac, at, amx, amn, ec, et, emx, emn);
      end
   endtask

   task automatic drive(input logic c, input logic l, input logic [3:0] d,
                        input logic e, input logic u);
      clear_in = c; load_in = l; d_in = d; en_in = e; up_in = u;
   endtask

   initial begin
      reset_al_in = 1'b0;
      drive(0, 0, 4'd0, 0, 1);

      // Wrap-mode count up through the modulus
      vecs.push_back(mk("clr_start", 0, 1, 0, 0, 0, 1, 0, 0, 0, 1));
      for (int k = 1; k <= 9; k++)
         vecs.push_back(mk("up_seq", 0, 0, 0, 0, 1, 1, 4'(k), 0, (k == 9), 0));
      vecs.push_back(mk("up_wrap0", 0, 0, 0, 0, 1, 1, 0, 1, 0, 1));
      vecs.push_back(mk("up_after_wrap", 0, 0, 0, 0, 1, 1, 1, 0, 0, 0));
      // Wrap-mode count down through zero
      vecs.push_back(mk("ld2", 0, 0, 1, 2, 0, 1, 2, 0, 0, 0));
      vecs.push_back(mk("dn1", 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
      vecs.push_back(mk("dn0", 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk("dn_wrap9", 0, 0, 0, 0, 1, 0, 9, 1, 1, 0));
      vecs.push_back(mk("dn8", 0, 0, 0, 0, 1, 0, 8, 0, 0, 0));
      vecs.push_back(mk("hold_en0", 0, 0, 0, 0, 0, 0, 8, 0, 0, 0));
      // Load clamp and load-over-tick
      vecs.push_back(mk("ld12_clamp", 0, 0, 1, 12, 0, 1, 9, 0, 1, 0));
      vecs.push_back(mk("ld3_with_en", 0, 0, 1, 3, 1, 1, 3, 0, 0, 0));
      vecs.push_back(mk("ld9", 0, 0, 1, 9, 0, 1, 9, 0, 1, 0));
      vecs.push_back(mk("ld9_at_max_en", 0, 0, 1, 9, 1, 1, 9, 0, 1, 0));
      vecs.push_back(mk("tick_at_max", 0, 0, 0, 0, 1, 1, 0, 1, 0, 1));
      // Clear beats load and tick
      vecs.push_back(mk("ld7", 0, 0, 1, 7, 0, 1, 7, 0, 0, 0));
      vecs.push_back(mk("clr_ld_en", 0, 1, 1, 5, 1, 1, 0, 0, 0, 1));
      vecs.push_back(mk("ld9b", 0, 0, 1, 9, 0, 1, 9, 0, 1, 0));
      vecs.push_back(mk("clr_en_at_max", 0, 1, 0, 0, 1, 1, 0, 0, 0, 1));
      // Saturate mode at both boundaries
      vecs.push_back(mk("sat_ld2", 1, 0, 1, 2, 0, 0, 2, 0, 0, 0));
      vecs.push_back(mk("sat_dn1", 1, 0, 0, 0, 1, 0, 1, 0, 0, 0));
      vecs.push_back(mk("sat_dn0", 1, 0, 0, 0, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk("sat_hold0_a", 1, 0, 0, 0, 1, 0, 0, 1, 0, 1));
      vecs.push_back(mk("sat_hold0_b", 1, 0, 0, 0, 1, 0, 0, 1, 0, 1));
      vecs.push_back(mk("sat_up1", 1, 0, 0, 0, 1, 1, 1, 0, 0, 0));
      vecs.push_back(mk("sat_ld9", 1, 0, 1, 9, 0, 1, 9, 0, 1, 0));
      vecs.push_back(mk("sat_hold9_a", 1, 0, 0, 0, 1, 1, 9, 1, 1, 0));
      vecs.push_back(mk("sat_hold9_b", 1, 0, 0, 0, 1, 1, 9, 1, 1, 0));
      vecs.push_back(mk("sat_no_tick", 1, 0, 0, 0, 0, 1, 9, 0, 1, 0));
      vecs.push_back(mk("sat_dn8", 1, 0, 0, 0, 1, 0, 8, 0, 0, 0));

      // Reset state, no clock edge needed after the reset falls
      #3;
      check(0, "por_wrap", 0, 0, 0, 1);
      check(1, "por_sat", 0, 0, 0, 1);
      check(2, "por_pre", 0, 0, 0, 1);
      step();
      #3 reset_al_in = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].clr, vecs[i].ld, vecs[i].d, vecs[i].en, vecs[i].up);
         step();
         check(vecs[i].sel, vecs[i].name, vecs[i].cnt, vecs[i].tc, vecs[i].mx, vecs[i].mn);
      end

      // Mid-cycle reset while tc is high
      drive(0, 1, 9, 0, 1);
      step();
      drive(0, 0, 0, 1, 1);
      step();
      check(1, "sat_tc_before_rst", 9, 1, 1, 0);
      drive(0, 0, 0, 0, 1);
      #3 reset_al_in = 1'b0;
      #1 check(1, "rst_async_tc", 0, 0, 0, 1);
      #3 reset_al_in = 1'b1;

      // Mid-cycle reset from count 5, held across an enabled edge
      drive(0, 1, 5, 0, 1);
      step();
      check(0, "ld5_before_rst", 5, 0, 0, 0);
      drive(0, 0, 0, 1, 1);
      #3 reset_al_in = 1'b0;
      #1 check(0, "rst_async_cnt", 0, 0, 0, 1);
      step();
      check(0, "rst_held_low", 0, 0, 0, 1);
      #3 reset_al_in = 1'b1;
      step();
      check(0, "first_edge_after_rst", 1, 0, 0, 0);

      // Prescale by 3
      drive(1, 0, 0, 0, 1);
      step();
      check(2, "pre_clr", 0, 0, 0, 1);
      drive(0, 0, 0, 1, 1);
      for (int i = 1; i <= 6; i++) begin
         step();
         check(2, "pre_run", 4'(i / 3), 0, 0, (i < 3));
      end
      step();
      check(2, "pre_phase1", 2, 0, 0, 0);
      en_in = 1'b0;
      step();
      check(2, "pre_gap_a", 2, 0, 0, 0);
      step();
      check(2, "pre_gap_b", 2, 0, 0, 0);
      en_in = 1'b1;
      step();
      check(2, "pre_resume_a", 2, 0, 0, 0);
      step();
      check(2, "pre_resume_tick", 3, 0, 0, 0);
      drive(0, 1, 5, 1, 1);
      step();
      check(2, "pre_load5", 5, 0, 0, 0);
      drive(0, 0, 0, 1, 1);
      step();
      check(2, "pre_after_ld_a", 5, 0, 0, 0);
      step();
      check(2, "pre_after_ld_b", 5, 0, 0, 0);
      step();
      check(2, "pre_after_ld_tick", 6, 0, 0, 0);
      // Direction seen only at the tick
      up_in = 1'b0;
      step();
      check(2, "pre_dir_a", 6, 0, 0, 0);
      step();
      check(2, "pre_dir_b", 6, 0, 0, 0);
      up_in = 1'b1;
      step();
      check(2, "pre_dir_tick_up", 7, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
